// File: rtl/hamming74_encoder_tx_if.sv
// Handshake bundle for the Hamming(7,4) transmitter: nibble input side and codeword output side.
// master = producer of nibbles / consumer of codewords; slave = the encoder itself.
interface hamming74_encoder_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [2:0] in_inj_pos;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_code;

    modport master (
        output in_valid,
        output in_data,
        output in_inj_pos,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_code
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_inj_pos,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_code
    );
endinterface

// File: rtl/hamming74_encoder_tx.sv
// Buffers nibbles in a small FIFO and emits Hamming(7,4) codewords with optional bit-flip injection.
// Latency 2 cycles push-to-out_valid when idle, then one word per cycle; in_ready = FIFO not full (registered state only).
// Output register holds while out_ready is low. HAMMING_SECDED_EN adds the overall parity bit out_code[7].
module hamming74_encoder_tx #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    hamming74_encoder_tx_if.slave bus,
    output logic [CNT_W-1:0]     word_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    // Each entry carries the injection position alongside the nibble: {pos[2:0], d[3:0]}
    logic [6:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic [6:0]  head_dat;
    logic [3:0]  head_d;
    logic [2:0]  head_pos;

    logic [6:0]  code_clean;
    logic [6:0]  code_inj;
    logic        parity;

    logic        out_valid_q;
    logic [7:0]  out_code_q;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign bus.in_ready = !fifo_full;
    assign push         = bus.in_valid && !fifo_full;
    // Refill the output register whenever it is empty or being drained this cycle.
    assign pop          = !fifo_empty && (!out_valid_q || bus.out_ready);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {bus.in_inj_pos, bus.in_data};
        end
    end

    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign head_d   = head_dat[3:0];
    assign head_pos = head_dat[6:4];

    function automatic logic [6:0] encode(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    function automatic logic [6:0] inj_mask(input logic [2:0] pos);
        logic [6:0] m;
        m = '0;
        if (pos != 3'd0) begin
            m[pos - 3'd1] = 1'b1;
        end
        return m;
    endfunction

    assign code_clean = encode(head_d);
    assign code_inj   = code_clean ^ inj_mask(head_pos);

`ifdef HAMMING_SECDED_EN
    // Parity covers the clean codeword so an injected flip shows up as odd overall parity.
    assign parity = ^code_clean;
`else
    assign parity = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_code_q  <= {parity, code_inj};
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            word_cnt <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            word_cnt <= word_cnt + CNT_ONE;
        end
    end

    a_hold_stable: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        out_valid_q && !bus.out_ready |=> out_valid_q && $stable(out_code_q));

    a_no_overflow: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        fifo_full |-> !push);

    c_cnt_wrap: cover property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        out_valid_q && bus.out_ready && (&word_cnt));

endmodule

// File: doc/hamming74_encoder_tx.md
Name: hamming74_encoder_tx

Overview:
- Transmit-side counterpart to the 7-bit codeword decoder in the decoder project.
- Accepts 4-bit data nibbles over a valid/ready handshake and buffers them in a small FIFO.
- Encodes each nibble into a Hamming(7,4) codeword, with optional single-bit error injection, and presents it on a registered valid/ready output that can drive the decoder's 7-bit io_in.
- Counts delivered codewords for bring-up and formal cover.

Parameters:
- FIFO_DEPTH, 2, input buffer entries; power of 2, minimum 2.
- CNT_W, 16, width of the delivered-codeword counter.

Ports:
- wb_clk_i  input  1  clock; all state updates on the rising edge.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- in_valid  input  1  nibble offered.
- in_ready  output 1  FIFO can accept; high when FIFO not full.
- in_data  input  4  data nibble d[3:0].
- in_inj_pos  input  3  error injection position, sampled with in_data; 0 = none, 1..7 = flip codeword bit (pos-1).
- out_valid  output 1  out_code holds a codeword.
- out_ready  input  1  consumer accepts.
- out_code  output 8  [6:0] codeword, [7] overall parity (see Optional Feature).
- word_cnt  output CNT_W  number of completed output handshakes, modulo 2^CNT_W.

Behaviour:
- Reset (async assert, release synchronous to wb_clk_i):
  - FIFO empties; out_valid=0; out_code=0; word_cnt=0.
  - in_ready=1 from the first edge after release.
- Input push: on in_valid&in_ready, {in_inj_pos,in_data} is written at the write pointer. Pointers have log2(FIFO_DEPTH)+1 bits; wrap-around is natural.
  - full = pointers differ only in the MSB.
  - empty = pointers equal.
- Output register: loads from the FIFO head when FIFO is non-empty AND (out_valid==0 OR out_ready==1); the FIFO pops in the same cycle.
  - Latency: a nibble pushed in cycle N appears with out_valid=1 in cycle N+2 when FIFO and output are idle.
  - Steady state: one word per cycle.
- Simultaneous push and pop with a full FIFO: in_ready is 0 that cycle (it depends on the registered full flag only), so no push occurs. Push and pop in the same cycle with a non-full FIFO are both performed.
- Hold: while out_valid=1 and out_ready=0, out_code is held stable; no pop occurs.
- out_valid drops to 0 when out_ready=1 and the FIFO is empty.
- Encoding, with bit c[i] at Hamming position i+1:
  - c[0]=p1=d0^d1^d3
  - c[1]=p2=d0^d2^d3
  - c[2]=d0
  - c[3]=p4=d1^d2^d3
  - c[4]=d1
  - c[5]=d2
  - c[6]=d3
- Injection: if pos!=0, c[pos-1] is inverted after encoding. Injection does not affect c[7] calculation order (see Optional Feature).
- word_cnt increments on every out_valid&out_ready and wraps from 2^CNT_W-1 to 0.
- Reset mid-transfer: buffered and held words are discarded and word_cnt clears. No output handshake is recognised during reset.
- No combinational path from out_ready to in_ready.

Optional Feature:
- Macro: HAMMING_SECDED_EN.
- Defined: out_code[7] = XOR of the 7 encoded bits computed BEFORE injection. Codeword is SECDED (8,4); an injected error makes overall parity odd.
- Undefined: out_code[7] is tied to 0, and no parity logic is present.

Test Plan:
- Reset then push d=4'b1011, pos=0, out_ready=1 → two cycles later out_valid=1, out_code[6:0]=7'b1010101; word_cnt=1 the cycle after the handshake.
- Push d=4'b0001, pos=0 with HAMMING_SECDED_EN → out_code=8'b10000111; without the macro → 8'b00000111.
- Push d=4'b0000, pos=3 → out_code[6:0]=7'b0000100; with SECDED, out_code[7]=0.
- Hold out_ready=0 and push 3 nibbles (FIFO_DEPTH=2):
  - in_ready falls after the 3rd push (1 word in the output register, 2 in the FIFO).
  - out_code stays stable; release out_ready → words emerge in push order on consecutive cycles.
- Continuous in_valid=out_ready=1 over all 16 nibbles → 16 back-to-back codewords matching the formulas (4'b1111 → 7'b1111111); word_cnt=16.
- Assert wb_rst_i asynchronously with 2 words buffered → out_valid and word_cnt go 0 immediately, without waiting for a clock edge; after release, no stale word appears.
